// File: rtl/reg_file_sb.sv
// 32 x 32-bit integer register file (x0 hardwired to zero) with two registered read
// ports, a write-first bypass, and a pending-write scoreboard that stalls read-after-write hazards.
module reg_file_sb #(
    parameter logic [31:0] STACK_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_en,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic        issue_en,
    input  logic [4:0]  issue_dest,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        rvalid,
    output logic        stall,
    output logic        busy
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic [XLEN-1:0] rdata1_q, rdata2_q, rdata1_d, rdata2_d;
    logic            rvalid_q, rvalid_d;
    logic            busy_q, busy_d;
    logic            wr_c, haz1_c, haz2_c, stall_c, accept_c;

    // Operand read with write-first bypass; x0 always reads as zero.
    function automatic logic [XLEN-1:0] read_op(input logic [AW-1:0] addr,
                                                input logic            wr,
                                                input logic [AW-1:0]   wa,
                                                input logic [XLEN-1:0] wd,
                                                input logic [XLEN-1:0] stored);
        if (addr == AW'(0))          return XLEN'(0);
        else if (wr && (wa == addr)) return wd;
        else                         return stored;
    endfunction

    // Hazard detection, scoreboard next state and read-port next state.
    always_comb begin
        wr_c     = w_en && (waddr != AW'(0));
        haz1_c   = pend_q[raddr1] && !(wr_c && (waddr == raddr1));
        haz2_c   = pend_q[raddr2] && !(wr_c && (waddr == raddr2));
        stall_c  = rd_en && (haz1_c || haz2_c);
        accept_c = rd_en && !stall_c;

        pend_d = pend_q;
        if (wr_c) pend_d[waddr] = 1'b0;
        // Set after clear: the newly issued producer is the one outstanding.
        if (issue_en && !stall_c && (issue_dest != AW'(0))) pend_d[issue_dest] = 1'b1;
        pend_d[0] = 1'b0;
        busy_d    = |pend_d;

        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        rvalid_d = accept_c;
        if (accept_c) begin
            rdata1_d = read_op(raddr1, wr_c, waddr, wdata, regs_q[raddr1]);
            rdata2_d = read_op(raddr2, wr_c, waddr, wdata, regs_q[raddr2]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= (i == 2) ? STACK_ADDR : XLEN'(0);
            end
        end else if (wr_c) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q   <= NREG'(0);
            rdata1_q <= XLEN'(0);
            rdata2_q <= XLEN'(0);
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
        end
    end

    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;
    assign rvalid = rvalid_q;
    assign busy   = busy_q;
    assign stall  = stall_c;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: expected read results are queued at issue time and
// a negedge monitor pops and compares them whenever rvalid is presented.
module tb_reg_file_sb;

    localparam logic [31:0] SP = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_en, rd_en, issue_en;
    logic [4:0]  waddr, raddr1, raddr2, issue_dest;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2;
    logic        rvalid, stall, busy;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    reg_file_sb #(.STACK_ADDR(SP)) dut (
        .clk(clk), .reset(reset),
        .w_en(w_en), .waddr(waddr), .wdata(wdata),
        .rd_en(rd_en), .raddr1(raddr1), .raddr2(raddr2),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .rdata1(rdata1), .rdata2(rdata2), .rvalid(rvalid),
        .stall(stall), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // Scoreboard monitor: every presented read must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rvalid: got rdata1=%h rdata2=%h expected no read", rdata1, rdata2);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_rdata1", rdata1, e.d1);
                chk("sb_rdata2", rdata2, e.d2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_en = 0; rd_en = 0; issue_en = 0;
        waddr = 0; wdata = 0; raddr1 = 0; raddr2 = 0; issue_dest = 0;
    endtask

    task automatic expect_read(input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        e.d1 = d1;
        e.d2 = d2;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 0;
        tick(); tick();
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_rdata1", rdata1, 32'd0);
        chk("reset_stall",  32'(stall),  32'd0);
        #2 reset = 1;
        tick();

        // Reset values: x2 = stack address, x5 = 0.
        rd_en = 1; raddr1 = 2; raddr2 = 5;
        #1 chk("sp_read_stall", 32'(stall), 32'd0);
        expect_read(SP, 32'd0);
        tick(); idle();
        chk("sp_read_rvalid", 32'(rvalid), 32'd1);

        // Write to x0 is dropped.
        w_en = 1; waddr = 0; wdata = 32'hDEAD_BEEF;
        tick(); idle();
        rd_en = 1; raddr1 = 0; raddr2 = 0;
        expect_read(32'd0, 32'd0);
        tick(); idle();

        // Same-cycle write bypass, then the stored value.
        w_en = 1; waddr = 7; wdata = 32'h1234_5678;
        rd_en = 1; raddr1 = 2; raddr2 = 7;
        expect_read(SP, 32'h1234_5678);
        tick(); idle();
        rd_en = 1; raddr1 = 7; raddr2 = 7;
        expect_read(32'h1234_5678, 32'h1234_5678);
        tick(); idle();

        // RAW hazard on x9 resolved by the retiring write.
        issue_en = 1; issue_dest = 9;
        tick(); idle();
        chk("issue9_busy", 32'(busy), 32'd1);
        rd_en = 1; raddr1 = 9; raddr2 = 0;
        #1 chk("haz9_stall", 32'(stall), 32'd1);
        tick();
        chk("haz9_rvalid", 32'(rvalid), 32'd0);
        chk("haz9_stall_hold", 32'(stall), 32'd1);
        w_en = 1; waddr = 9; wdata = 32'hCAFE_0001;
        #1 chk("haz9_resolve_stall", 32'(stall), 32'd0);
        expect_read(32'hCAFE_0001, 32'd0);
        tick(); idle();
        chk("haz9_done_rvalid", 32'(rvalid), 32'd1);
        chk("haz9_done_busy", 32'(busy), 32'd0);

        // Issue while stalled is ignored.
        issue_en = 1; issue_dest = 9;
        tick(); idle();
        rd_en = 1; raddr1 = 9; issue_en = 1; issue_dest = 3;
        #1 chk("stalled_issue_stall", 32'(stall), 32'd1);
        tick(); idle();
        rd_en = 1; raddr1 = 3; raddr2 = 0;
        #1 chk("x3_not_pending", 32'(stall), 32'd0);
        expect_read(32'd0, 32'd0);
        tick(); idle();
        chk("x9_still_busy", 32'(busy), 32'd1);
        w_en = 1; waddr = 9; wdata = 32'h0000_0099;
        tick(); idle();
        chk("x9_retired_busy", 32'(busy), 32'd0);

        // Set and clear of x4 in one cycle: set wins.
        issue_en = 1; issue_dest = 4;
        tick(); idle();
        issue_en = 1; issue_dest = 4; w_en = 1; waddr = 4; wdata = 32'h0000_0044;
        tick(); idle();
        chk("x4_busy", 32'(busy), 32'd1);
        rd_en = 1; raddr1 = 4; raddr2 = 7;
        #1 chk("x4_stall", 32'(stall), 32'd1);
        tick();
        chk("x4_stall_rvalid", 32'(rvalid), 32'd0);
        w_en = 1; waddr = 4; wdata = 32'h0000_4444;
        #1 chk("x4_resolve_stall", 32'(stall), 32'd0);
        expect_read(32'h0000_4444, 32'h1234_5678);
        tick(); idle();
        chk("x4_done_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-operation.
        w_en = 1; waddr = 10; wdata = 32'hA5A5_A5A5;
        tick(); idle();
        issue_en = 1; issue_dest = 11; rd_en = 1; raddr1 = 10; raddr2 = 0;
        tick(); idle();
        chk("pre_reset_rvalid", 32'(rvalid), 32'd1);
        chk("pre_reset_rdata1", rdata1, 32'hA5A5_A5A5);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #1 reset = 0;
        #1 chk("async_rvalid", 32'(rvalid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_rdata1", rdata1, 32'd0);
        #1 reset = 1;
        tick();
        rd_en = 1; raddr1 = 10; raddr2 = 11;
        #1 chk("post_reset_x11_stall", 32'(stall), 32'd0);
        expect_read(32'd0, 32'd0);
        tick(); idle();
        rd_en = 1; raddr1 = 2; raddr2 = 7;
        expect_read(SP, 32'd0);
        tick(); idle();

        tick(); tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
